// File: rtl/mm_step_scheduler.sv
// K-dimension step scheduler for the PE-array matrix multiply: per k it issues a fetch,
// collects per-PE operand acks (sticky), pulses accumulate, and pulses done after the last step.
module mm_step_scheduler #(
  parameter int ROW1    = 2,
  parameter int COL1    = 3,
  parameter int COL2    = 5,
  parameter int TIMEOUT = 64,
  localparam int NPE    = ROW1 * COL2,
  localparam int KW     = (COL1 > 1) ? $clog2(COL1) : 1,
  localparam int TW     = $clog2(TIMEOUT + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [NPE-1:0] pe_ack,
  output logic           busy,
  output logic           fetch_req,
  output logic [KW-1:0]  k_idx,
  output logic           acc_en,
  output logic           done,
  output logic           error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_ACK,
    ST_ACCUM,
    ST_DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [KW-1:0]  r_k_idx;
  logic [KW-1:0]  w_k_idx_next;
  logic [KW-1:0]  w_k_inc;
  logic [NPE-1:0] r_ack_seen;
  logic [NPE-1:0] w_ack_seen_next;
  logic [NPE-1:0] w_ack_merged;
  logic [TW-1:0]  r_wait_cnt;
  logic [TW-1:0]  w_wait_cnt_next;
  logic           r_error;
  logic           w_error_next;
  logic           w_all_acked;
  logic           w_timeout;
  logic           w_last_step;

  // Acks arriving this cycle count toward completion immediately.
  assign w_ack_merged = r_ack_seen | pe_ack;
  assign w_all_acked  = &w_ack_merged;
  assign w_timeout    = (r_wait_cnt == TW'(TIMEOUT - 1));

  generate
    if (COL1 > 1) begin : g_multi_step
      assign w_last_step = (r_k_idx == KW'(COL1 - 1));
      assign w_k_inc     = r_k_idx + KW'(1);
    end else begin : g_single_step
      assign w_last_step = 1'b1;
      assign w_k_inc     = '0;
    end
  endgenerate

  always_comb begin
    w_state_next    = r_state;
    w_k_idx_next    = r_k_idx;
    w_ack_seen_next = r_ack_seen;
    w_wait_cnt_next = r_wait_cnt;
    w_error_next    = r_error;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next    = ST_FETCH;
          w_k_idx_next    = '0;
          w_error_next    = 1'b0;
          w_ack_seen_next = '0;
        end
      end
      ST_FETCH: begin
        w_ack_seen_next = '0;
        w_wait_cnt_next = '0;
        w_state_next    = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        w_ack_seen_next = w_ack_merged;
        w_wait_cnt_next = r_wait_cnt + TW'(1);
        // Completion takes priority over a coincident timeout.
        if (w_all_acked) begin
          w_state_next = ST_ACCUM;
        end else if (w_timeout) begin
          w_state_next = ST_IDLE;
          w_error_next = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (w_last_step) begin
          w_state_next = ST_DONE;
        end else begin
          w_k_idx_next = w_k_inc;
          w_state_next = ST_FETCH;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_k_idx    <= '0;
      r_ack_seen <= '0;
      r_wait_cnt <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_k_idx    <= w_k_idx_next;
      r_ack_seen <= w_ack_seen_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_error    <= w_error_next;
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign fetch_req = (r_state == ST_FETCH);
  assign acc_en    = (r_state == ST_ACCUM);
  assign done      = (r_state == ST_DONE);
  assign k_idx     = r_k_idx;
  assign error     = r_error;

endmodule

// File: tb/tb_mm_step_scheduler.sv
// Bench for mm_step_scheduler: fixed vector table, directed corner runs and randomized runs
// checked against a timeline model built from per-PE ack arrival offsets.
module tb_mm_step_scheduler;
  localparam int ROW1    = 2;
  localparam int COL1    = 3;
  localparam int COL2    = 2;
  localparam int TIMEOUT = 8;
  localparam int NPE     = ROW1 * COL2;
  localparam int KW      = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b1;
  logic [NPE-1:0] pe_ack = '1;
  logic           busy;
  logic           fetch_req;
  logic [KW-1:0]  k_idx;
  logic           acc_en;
  logic           done;
  logic           error;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state carried between runs: k_idx and error as left by the previous run.
  logic [KW-1:0] m_k   = '0;
  logic          m_err = 1'b0;
  // Ack arrival offset per step and PE, in WAIT cycles; >= TIMEOUT means never.
  int m_offs [COL1][NPE];

  always #5 clk = ~clk;

  mm_step_scheduler #(
    .ROW1(ROW1), .COL1(COL1), .COL2(COL2), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pe_ack(pe_ack),
    .busy(busy), .fetch_req(fetch_req), .k_idx(k_idx),
    .acc_en(acc_en), .done(done), .error(error)
  );

  // Expected vector layout: {busy, fetch_req, k_idx[1:0], acc_en, done, error}
  function automatic logic [6:0] ex(input logic b, input logic f, input logic [KW-1:0] k,
                                    input logic a, input logic d, input logic e);
    return {b, f, k, a, d, e};
  endfunction

  // One cycle: check outputs registered at the previous edge, then drive inputs for the next edge.
  task automatic apply(input logic r, input logic s, input logic [NPE-1:0] a,
                       input logic [6:0] exp_v, input string name, input int cyc);
    logic [6:0] act;
    @(negedge clk);
    act = {busy, fetch_req, k_idx, acc_en, done, error};
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got {busy,fetch,k,acc,done,err}=%b required %b",
               name, cyc, act, exp_v);
    end
    rst    = r;
    start  = s;
    pe_ack = a;
  endtask

  task automatic set_offs(input int v);
    for (int k = 0; k < COL1; k++)
      for (int p = 0; p < NPE; p++)
        m_offs[k][p] = v;
  endtask

  // Build the expected cycle-by-cycle timeline of one started run, then play it.
  task automatic run_model(input bit noise, input string name);
    logic [6:0]     eq[$];
    logic [NPE-1:0] aq[$];
    logic           sq[$];
    logic [NPE-1:0] a;
    int             maxd;
    int             nw;
    bit             timed;
    timed = 1'b0;
    eq.push_back(ex(1'b0, 1'b0, m_k, 1'b0, 1'b0, m_err));
    sq.push_back(1'b1);
    aq.push_back(noise ? NPE'($urandom) : '0);
    for (int k = 0; k < COL1 && !timed; k++) begin
      maxd = 0;
      for (int p = 0; p < NPE; p++)
        if (m_offs[k][p] > maxd) maxd = m_offs[k][p];
      timed = (maxd >= TIMEOUT);
      nw    = timed ? TIMEOUT : maxd + 1;
      eq.push_back(ex(1'b1, 1'b1, KW'(k), 1'b0, 1'b0, 1'b0));
      sq.push_back(noise ? 1'($urandom_range(0, 1)) : 1'b0);
      aq.push_back(noise ? NPE'($urandom) : '0);
      for (int w = 0; w < nw; w++) begin
        a = '0;
        for (int p = 0; p < NPE; p++) begin
          if (m_offs[k][p] == w) a[p] = 1'b1;
          else if (noise && m_offs[k][p] < w) a[p] = 1'($urandom_range(0, 1));
        end
        eq.push_back(ex(1'b1, 1'b0, KW'(k), 1'b0, 1'b0, 1'b0));
        sq.push_back(noise ? 1'($urandom_range(0, 1)) : 1'b0);
        aq.push_back(a);
      end
      if (timed) begin
        eq.push_back(ex(1'b0, 1'b0, KW'(k), 1'b0, 1'b0, 1'b1));
        sq.push_back(1'b0);
        aq.push_back('0);
        m_k   = KW'(k);
        m_err = 1'b1;
      end else begin
        eq.push_back(ex(1'b1, 1'b0, KW'(k), 1'b1, 1'b0, 1'b0));
        sq.push_back(noise ? 1'($urandom_range(0, 1)) : 1'b0);
        aq.push_back(noise ? NPE'($urandom) : '0);
      end
    end
    if (!timed) begin
      eq.push_back(ex(1'b1, 1'b0, KW'(COL1 - 1), 1'b0, 1'b1, 1'b0));
      sq.push_back(noise ? 1'($urandom_range(0, 1)) : 1'b0);
      aq.push_back(noise ? NPE'($urandom) : '0);
      eq.push_back(ex(1'b0, 1'b0, KW'(COL1 - 1), 1'b0, 1'b0, 1'b0));
      sq.push_back(1'b0);
      aq.push_back(noise ? NPE'($urandom) : '0);
      m_k   = KW'(COL1 - 1);
      m_err = 1'b0;
    end
    for (int i = 0; i < eq.size(); i++)
      apply(1'b1, sq[i], aq[i], eq[i], name, i);
    $display("run %s: %0d cycles, timed_out=%0d", name, eq.size(), timed);
  endtask

  typedef struct {
    logic           r;
    logic           s;
    logic [NPE-1:0] a;
    logic [6:0]     e;
  } vec_t;

  initial begin
    vec_t tbl[$];
    // Reset held with start and acks asserted: everything stays low.
    for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 1'b1, 4'hF, 7'b0000000});
    tbl.push_back('{1'b1, 1'b0, 4'hF, 7'b0000000});
    // Nominal run, all acks constantly high; then the same with start pulses while busy.
    for (int pass = 0; pass < 2; pass++) begin
      tbl.push_back('{1'b1, 1'b1, 4'hF, (pass == 0) ? 7'b0000000 : 7'b0010000});
      tbl.push_back('{1'b1, 1'b0, 4'hF, 7'b1100000});
      tbl.push_back('{1'b1, pass == 1, 4'hF, 7'b1000000});
      tbl.push_back('{1'b1, pass == 1, 4'hF, 7'b1000100});
      tbl.push_back('{1'b1, 1'b0, 4'hF, 7'b1101000});
      tbl.push_back('{1'b1, pass == 1, 4'hF, 7'b1001000});
      tbl.push_back('{1'b1, 1'b0, 4'hF, 7'b1001100});
      tbl.push_back('{1'b1, 1'b0, 4'hF, 7'b1110000});
      tbl.push_back('{1'b1, pass == 1, 4'hF, 7'b1010000});
      tbl.push_back('{1'b1, 1'b0, 4'hF, 7'b1010100});
      tbl.push_back('{1'b1, pass == 1, 4'hF, 7'b1010010});
      tbl.push_back('{1'b1, 1'b0, 4'hF, 7'b0010000});
    end
    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].e, "table", i);
    $display("run table: %0d vectors", tbl.size());
    m_k   = 2'd2;
    m_err = 1'b0;

    // Staggered acks on the first step.
    set_offs(0);
    m_offs[0][2] = 2;
    m_offs[0][3] = 2;
    run_model(1'b0, "staggered");

    // PE 3 never acks: timeout, sticky error, no accumulate.
    set_offs(0);
    m_offs[0][3] = TIMEOUT;
    run_model(1'b0, "timeout");

    // Last ack on the final WAIT cycle: completion beats timeout; also clears error.
    set_offs(0);
    m_offs[1][0] = TIMEOUT - 1;
    run_model(1'b0, "boundary");

    // Reset mid-run, then a fresh start.
    set_offs(0);
    apply(1'b1, 1'b1, 4'hF, ex(1'b0, 1'b0, m_k, 1'b0, 1'b0, m_err), "midreset", 0);
    apply(1'b1, 1'b0, 4'hF, 7'b1100000, "midreset", 1);
    apply(1'b1, 1'b0, 4'hF, 7'b1000000, "midreset", 2);
    apply(1'b1, 1'b0, 4'hF, 7'b1000100, "midreset", 3);
    apply(1'b1, 1'b0, 4'hF, 7'b1101000, "midreset", 4);
    apply(1'b0, 1'b1, 4'hF, 7'b1001000, "midreset", 5);
    apply(1'b0, 1'b1, 4'hF, 7'b0000000, "midreset", 6);
    apply(1'b1, 1'b0, 4'h0, 7'b0000000, "midreset", 7);
    apply(1'b1, 1'b0, 4'h0, 7'b0000000, "midreset", 8);
    $display("run midreset: 9 cycles");
    m_k   = '0;
    m_err = 1'b0;
    run_model(1'b0, "after_reset");

    // Randomized runs with noise on start and on pe_ack outside the relevant windows.
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < COL1; k++)
        for (int p = 0; p < NPE; p++)
          m_offs[k][p] = $urandom_range(0, 3);
      case ($urandom_range(0, 7))
        0: m_offs[$urandom_range(0, COL1 - 1)][$urandom_range(0, NPE - 1)] = TIMEOUT;
        1: m_offs[$urandom_range(0, COL1 - 1)][$urandom_range(0, NPE - 1)] = TIMEOUT - 1;
        default: ;
      endcase
      run_model(1'b1, $sformatf("random%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
